// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: shared frame-decoder state encoding and default framing constants
package uart_rx_frame_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_e;
    localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;
    localparam int DEF_MAX_LEN = 16;
endpackage

// File: rtl/frame_buf.sv
// frame_buf: single-clock payload RAM with synchronous write and registered read
module frame_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [2**AW];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: SOF/LEN/payload/CHK frame decoder with buffered, backpressured payload drain
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = DEF_SOF_BYTE,
    parameter int         MAX_LEN        = DEF_MAX_LEN,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    state_e        r_state;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [7:0]    r_chk;
    logic [TW-1:0] r_tmo;
    logic          r_out_valid;
    logic          r_frame_ok;
    logic          r_frame_err;
    logic          w_timing;
    logic          w_timeout;
    logic          w_hs;
    logic          w_last;
    logic          w_we;
    logic [IW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;

    assign w_timing  = r_state inside {ST_LEN, ST_PAYLOAD, ST_CHK};
    assign w_timeout = w_timing && r_tmo == TMO_MAX;
    assign w_last    = r_rd_idx == r_len - 1'b1;
    assign w_hs      = r_state == ST_DRAIN && r_out_valid && out_ready;
    assign w_we      = r_state == ST_PAYLOAD && rx_data_valid && !w_timeout;
    // Look one entry ahead on a handshake so the next byte lands with no bubble
    assign w_rd_addr = w_hs ? r_rd_idx + 1'b1 : r_rd_idx;

    frame_buf #(.AW(IW)) u_frame_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_idx),
        .i_wdata (rx_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_chk       <= '0;
            r_tmo       <= '0;
            r_out_valid <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_tmo       <= (w_timing && !rx_data_valid && !w_timeout) ? r_tmo + 1'b1 : '0;
            if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: if (rx_data_valid && rx_data == SOF_BYTE) r_state <= ST_LEN;
                    ST_LEN: if (rx_data_valid) begin
                        if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                            r_state     <= ST_IDLE;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_len    <= rx_data[IW-1:0];
                            r_chk    <= rx_data;
                            r_wr_idx <= '0;
                            r_state  <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: if (rx_data_valid) begin
                        r_chk    <= r_chk ^ rx_data;
                        r_wr_idx <= r_wr_idx + 1'b1;
                        if (r_wr_idx == r_len - 1'b1) r_state <= ST_CHK;
                    end
                    ST_CHK: if (rx_data_valid) begin
                        r_frame_ok  <= rx_data == r_chk;
                        r_frame_err <= rx_data != r_chk;
                        r_rd_idx    <= '0;
                        r_state     <= rx_data == r_chk ? ST_DRAIN : ST_IDLE;
                    end
                    ST_DRAIN: begin
                        r_frame_err <= rx_data_valid;
                        if (!r_out_valid) begin
                            r_out_valid <= 1'b1;
                        end else if (out_ready) begin
                            if (w_last) begin
                                r_out_valid <= 1'b0;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_rd_idx <= r_rd_idx + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? w_rd_data : 8'h00;
    assign out_last  = r_out_valid && w_last;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign busy      = r_state != ST_IDLE;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frame sequences with hand-computed expectations
module tb_uart_rx_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid, out_last, frame_ok, frame_err, busy;
    logic [7:0] out_data;
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    uart_rx_frame_ctrl #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk1({tag, ".valid"}, out_valid, v);
        if (v) chk8({tag, ".data"}, out_data, d);
        chk1({tag, ".last"}, out_last, l);
    endtask

    task automatic chk_flags(input string tag, input logic ok, input logic err, input logic bsy);
        chk1({tag, ".frame_ok"}, frame_ok, ok);
        chk1({tag, ".frame_err"}, frame_err, err);
        chk1({tag, ".busy"}, busy, bsy);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 1'b0);
        chk8("reset.data", out_data, 8'h00);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // good frame: 03 ^ 11 ^ 22 ^ 33 = 03
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        chk_flags("good.chk", 1'b1, 1'b0, 1'b1);
        chk_out("good.chk", 1'b0, 8'h00, 1'b0);
        tick(); chk_out("good.b0", 1'b1, 8'h11, 1'b0);
        chk1("good.b0.frame_ok", frame_ok, 1'b0);
        tick(); chk_out("good.b1", 1'b1, 8'h22, 1'b0);
        tick(); chk_out("good.b2", 1'b1, 8'h33, 1'b1);
        tick(); chk_out("good.end", 1'b0, 8'h00, 1'b0);
        chk_flags("good.end", 1'b0, 1'b0, 1'b0);

        // bad checksum: correct would be 02 ^ 10 ^ 20 = 32
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        chk_flags("badchk", 1'b0, 1'b1, 1'b0);
        chk_out("badchk", 1'b0, 8'h00, 1'b0);
        tick(); chk_flags("badchk.after", 1'b0, 1'b0, 1'b0);
        chk_out("badchk.after", 1'b0, 8'h00, 1'b0);

        // length errors, then a valid one-byte frame: 01 ^ 7E = 7F
        send(8'hA5); send(8'h00);
        chk_flags("len0", 1'b0, 1'b1, 1'b0);
        send(8'hA5); send(8'h11);
        chk_flags("len17", 1'b0, 1'b1, 1'b0);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        chk_flags("len1.chk", 1'b1, 1'b0, 1'b1);
        tick(); chk_out("len1.b0", 1'b1, 8'h7E, 1'b1);
        tick(); chk_out("len1.end", 1'b0, 8'h00, 1'b0);
        chk1("len1.end.busy", busy, 1'b0);

        // backpressure 1,0,0,1 with an SOF-looking byte injected mid-drain: 02 ^ C3 ^ 3C = FD
        send(8'hA5); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFD);
        chk_flags("bp.chk", 1'b1, 1'b0, 1'b1);
        tick(); chk_out("bp.b0", 1'b1, 8'hC3, 1'b0);
        tick(); chk_out("bp.b1", 1'b1, 8'h3C, 1'b1);
        out_ready = 1'b0;
        send(8'hA5);
        chk_out("bp.stall1", 1'b1, 8'h3C, 1'b1);
        chk_flags("bp.stall1", 1'b0, 1'b1, 1'b1);
        tick(); chk_out("bp.stall2", 1'b1, 8'h3C, 1'b1);
        chk1("bp.stall2.frame_err", frame_err, 1'b0);
        out_ready = 1'b1;
        tick(); chk_out("bp.end", 1'b0, 8'h00, 1'b0);
        chk_flags("bp.end", 1'b0, 1'b0, 1'b0);
        tick(); chk1("bp.sof_dropped.busy", busy, 1'b0);

        // timeout: counter reads 20 in the 21st cycle after the last byte
        send(8'hA5); send(8'h04); send(8'h01);
        repeat (19) tick();
        chk_flags("tmo.before", 1'b0, 1'b0, 1'b1);
        tick();
        send(8'hA5);
        chk_flags("tmo.fire", 1'b0, 1'b1, 1'b0);
        tick(); chk_flags("tmo.after", 1'b0, 1'b0, 1'b0);

        // reset mid-payload, then a frame whose payload contains the SOF value: 02 ^ 5A ^ A5 = FD
        send(8'hA5); send(8'h03); send(8'hAA);
        chk1("rst.pre.busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("rst.mid", 1'b0, 8'h00, 1'b0);
        chk8("rst.mid.data", out_data, 8'h00);
        chk_flags("rst.mid", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        send(8'hA5); send(8'h02); send(8'h5A); send(8'hA5); send(8'hFD);
        chk_flags("rst.next.chk", 1'b1, 1'b0, 1'b1);
        tick(); chk_out("rst.next.b0", 1'b1, 8'h5A, 1'b0);
        tick(); chk_out("rst.next.b1", 1'b1, 8'hA5, 1'b1);
        tick(); chk_out("rst.next.end", 1'b0, 8'h00, 1'b0);
        chk1("rst.next.end.busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter SOF_BYTE, default 8'hA5: start-of-frame marker byte.
REQ-002 Parameter MAX_LEN, default 16: maximum payload length in bytes, range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 100_000: maximum clk cycles allowed between bytes inside a frame.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_data_valid  input  1  one-cycle strobe from the byte receiver; each high cycle delivers one byte.
REQ-007 rx_data  input  8  received byte; qualified by rx_data_valid.
REQ-008 out_valid  output  1  payload byte available on out_data.
REQ-009 out_data  output  8  payload byte, in order of arrival.
REQ-010 out_last  output  1  high with the final payload byte of a frame.
REQ-011 out_ready  input  1  downstream accepts the byte when out_valid && out_ready.
REQ-012 frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
REQ-013 frame_err  output  1  one-cycle pulse on bad length, bad checksum, timeout or overrun.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Frame format SHALL be SOF, LEN, LEN payload bytes, CHK, where CHK = LEN XOR all payload bytes.
REQ-016 State machine SHALL have states IDLE, LEN, PAYLOAD, CHK and DRAIN.
REQ-017 IDLE: a byte equal to SOF_BYTE goes to LEN; any other byte is discarded with no error pulse.
REQ-018 LEN: LEN of 0 or greater than MAX_LEN pulses frame_err and returns to IDLE; otherwise store LEN, seed the checksum with LEN and go to PAYLOAD.
REQ-019 PAYLOAD: write each byte to a MAX_LEN x 8 buffer at a write index starting at 0, XOR it into the checksum, and go to CHK after the LENth byte.
REQ-020 CHK: on a match, pulse frame_ok one cycle after the CHK byte strobe and enter DRAIN; on a mismatch, pulse frame_err and return to IDLE with the buffer discarded.
REQ-021 DRAIN: present buffer[0..LEN-1] in order; out_valid rises in the cycle after frame_ok; out_last is high only with index LEN-1.
REQ-022 While out_valid is high and out_ready is low, out_valid, out_data and out_last SHALL hold stable.
REQ-023 After the last-byte handshake, return to IDLE in the next cycle.
REQ-024 Any rx_data_valid during DRAIN SHALL pulse frame_err (overrun); the byte is dropped and the drain continues unaffected.
REQ-025 Inter-byte counter: cleared on each accepted byte in LEN, PAYLOAD or CHK, and counting otherwise in those states.
REQ-026 When the inter-byte counter reaches TIMEOUT_CYCLES, pulse frame_err and return to IDLE; there is no timeout in IDLE or DRAIN.
REQ-027 A byte strobe in the same cycle as a timeout SHALL be ignored; the timeout wins.
REQ-028 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-029 Counter and index widths SHALL be sized with $clog2 from the parameters, with the timeout counter saturating.

Reset
REQ-030 While rst is high: state IDLE; out_valid, out_last, frame_ok, frame_err and busy at 0; out_data at 8'h00; all counters, indices and the checksum at 0.
REQ-031 Reset asserted mid-frame or mid-drain SHALL abandon the frame without an error pulse; buffer contents need not be cleared.
REQ-032 After rst deasserts, the first byte SHALL be treated as an IDLE-state byte.

Structure
REQ-033 The state enumeration and the default SOF_BYTE and MAX_LEN constants SHALL live in the shared uart package.
REQ-034 The payload buffer SHALL be a sub-module, frame_buf: a synchronous-write, registered-read, single-clock RAM.
REQ-035 The FSM, checksum and timeout logic SHALL stay in uart_rx_frame_ctrl.

Verification
REQ-036 Good frame: bytes A5,03,11,22,33,03 with out_ready=1 -> frame_ok pulse; out_data sequence 11,22,33; out_last on 33.
REQ-037 Bad checksum: A5,02,10,20,00 -> frame_err pulse, no out_valid, busy=0 afterwards.
REQ-038 Length errors: A5,00 and A5,11 (with MAX_LEN=16) -> frame_err each time; a following valid frame is accepted.
REQ-039 Backpressure and overrun: good frame with out_ready toggling 1,0,0,1, plus a byte injected during DRAIN -> outputs stable while stalled, one frame_err, payload intact.
REQ-040 Timeout: A5,04,01 then TIMEOUT_CYCLES idle cycles -> frame_err and return to IDLE; a byte strobe in the timeout cycle is ignored.
REQ-041 Reset mid-PAYLOAD -> all outputs at 0 within the reset cycle, no pulse; the next frame decodes correctly.
